// File: rtl/comb_out_glitch_filter_if.sv
// comb_out_glitch_filter_if: raw level in, filtered level, strobes and counters out
interface comb_out_glitch_filter_if #(
    parameter int CNT_W = 8
);
    logic             F_in;
    logic             clr;
    logic             F_filt;
    logic             rise;
    logic             fall;
    logic             glitch;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] glitch_cnt;

    modport master (
        output F_in, clr,
        input  F_filt, rise, fall, glitch, edge_cnt, glitch_cnt
    );

    modport slave (
        input  F_in, clr,
        output F_filt, rise, fall, glitch, edge_cnt, glitch_cnt
    );
endinterface

// File: rtl/comb_out_glitch_filter.sv
// comb_out_glitch_filter: synchronise F, reject short pulses, strobe and count edges/glitches (GLITCH_CNT_EN builds glitch_cnt)
module comb_out_glitch_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    comb_out_glitch_filter_if.slave  bus
);
    typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;

    localparam logic [7:0]       LAST    = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       stab_q, stab_d;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    // two-flop synchroniser; only s2 is seen by the FSM
    always_comb begin
        s1_d = bus.F_in;
        s2_d = s1_q;
    end

    // next state: a CHK state confirms a new level or falls back on reversal
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        case (state_q)
            LOW:   if (s2_q) begin state_d = CHK_H; stab_d = 8'd1; end
            CHK_H: if (!s2_q) state_d = LOW;
                   else if (stab_q == LAST) state_d = HIGH;
                   else stab_d = stab_q + 8'd1;
            HIGH:  if (!s2_q) begin state_d = CHK_L; stab_d = 8'd1; end
            CHK_L: if (s2_q) state_d = HIGH;
                   else if (stab_q == LAST) state_d = LOW;
                   else stab_d = stab_q + 8'd1;
            default: state_d = LOW;
        endcase
    end

    // outputs: strobes decoded from the transition taken, counters saturate, clr wins
    always_comb begin
        rise_d     = (state_q == CHK_H) && (state_d == HIGH);
        fall_d     = (state_q == CHK_L) && (state_d == LOW);
        glitch_d   = ((state_q == CHK_H) && (state_d == LOW)) ||
                     ((state_q == CHK_L) && (state_d == HIGH));
        filt_d     = (state_d == HIGH) || (state_d == CHK_L);
        edge_cnt_d = bus.clr ? '0 :
                     ((rise_d || fall_d) && edge_cnt_q != CNT_MAX) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    end

    // all filter state, asynchronously reset to the idle-low condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOW;
            stab_q     <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            glitch_q   <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stab_q     <= stab_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_q     <= filt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            glitch_q   <= glitch_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

`ifdef GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // rejected-pulse count, same saturate/clear rules as edge_cnt
    always_comb begin
        glitch_cnt_d = bus.clr ? '0 :
                       (glitch_d && glitch_cnt_q != CNT_MAX) ? glitch_cnt_q + 1'b1 : glitch_cnt_q;
    end

    // glitch counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_cnt_q <= '0;
        else        glitch_cnt_q <= glitch_cnt_d;
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`else
    assign bus.glitch_cnt = '0;
`endif

    assign bus.F_filt   = filt_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.glitch   = glitch_q;
    assign bus.edge_cnt = edge_cnt_q;
endmodule

// File: tb/tb_comb_out_glitch_filter.sv
// tb_comb_out_glitch_filter: directed and random stimulus against a run-length reference model
module tb_comb_out_glitch_filter;
    localparam int S   = 4;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comb_out_glitch_filter_if #(.CNT_W(W)) bus ();
    comb_out_glitch_filter #(.STABLE_CYCLES(S), .CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int m_s1, m_s2, m_filt, m_run, m_ec, m_gc, m_rise, m_fall, m_gl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_filt = 0; m_run = 0;
        m_ec = 0; m_gc = 0; m_rise = 0; m_fall = 0; m_gl = 0;
    endtask

    // reference: count consecutive synchronised samples differing from the filtered level
    task automatic model_edge();
        int x;
        x = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(bus.F_in);
        m_rise = 0; m_fall = 0; m_gl = 0;
        if (x != m_filt) begin
            m_run++;
            if (m_run == S) begin
                m_filt = x; m_rise = x; m_fall = 1 - x; m_run = 0;
            end
        end else begin
            m_gl = (m_run > 0) ? 1 : 0;
            m_run = 0;
        end
        m_ec = bus.clr ? 0 : ((m_rise + m_fall) > 0 && m_ec < MAX) ? m_ec + 1 : m_ec;
`ifdef GLITCH_CNT_EN
        m_gc = bus.clr ? 0 : (m_gl > 0 && m_gc < MAX) ? m_gc + 1 : m_gc;
`else
        m_gc = 0;
`endif
    endtask

    task automatic check_all();
        check("F_filt", bus.F_filt, m_filt);
        check("rise", bus.rise, m_rise);
        check("fall", bus.fall, m_fall);
        check("glitch", bus.glitch, m_gl);
        check("edge_cnt", bus.edge_cnt, m_ec);
        check("glitch_cnt", bus.glitch_cnt, m_gc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input logic lvl, input int n);
        bus.F_in = lvl;
        repeat (n) step();
    endtask

    function automatic logic f_up(input logic [3:0] v);
        return (v[0] & v[1]) | (~v[0] & v[2]) | (v[1] & v[2]) | (v[3] & v[1]);
    endfunction

    initial begin
        bit seen;
        logic [3:0] vec;
        bus.F_in = 1'b0;
        bus.clr  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (20) step();
        check("idle_edge_cnt", bus.edge_cnt, 0);

        bus.F_in = 1'b1;
        repeat (5) step();
        check("lat_edge5", bus.F_filt, 0);
        step();
        check("lat_edge6", bus.F_filt, 1);
        hold(1'b1, 4);
        check("rise_edge_cnt", bus.edge_cnt, 1);
        hold(1'b0, 10);
        check("fall_edge_cnt", bus.edge_cnt, 2);

        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        hold(1'b1, 2);
        hold(1'b0, 10);
        hold(1'b1, 3);
        hold(1'b0, 10);
`ifdef GLITCH_CNT_EN
        check("pulses_glitch_cnt", bus.glitch_cnt, 2);
`else
        check("pulses_glitch_cnt", bus.glitch_cnt, 0);
`endif
        check("pulses_edge_cnt", bus.edge_cnt, 0);
        check("pulses_F_filt", bus.F_filt, 0);

        for (int i = 0; i < 20; i++) hold(~i[0], 6);
        check("sat_edge_cnt", bus.edge_cnt, MAX);

        seen = 1'b0;
        bus.F_in = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            bus.clr = (m_s2 == 1 && m_filt == 0 && m_run == S - 1);
            step();
            if (bus.clr) begin
                seen = 1'b1;
                check("clr_rise_strobe", bus.rise, 1);
                check("clr_rise_edge_cnt", bus.edge_cnt, 0);
            end
            bus.clr = 1'b0;
        end
        if (!seen) check("clr_rise_seen", 0, 1);

        hold(1'b0, 8);
        bus.F_in = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (5) step();
        check("rst_lat_edge5", bus.F_filt, 0);
        step();
        check("rst_lat_edge6", bus.F_filt, 1);
        check("rst_edge_cnt", bus.edge_cnt, 1);

        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        for (int v = 0; v < 16; v++) begin
            vec = 4'(v);
            hold(f_up(vec), 8);
            vec[v % 4] = ~vec[v % 4];
            hold(f_up(vec), 8);
            check("hazard_glitch_cnt", bus.glitch_cnt, 0);
        end

        for (int i = 0; i < 300; i++) begin
            bus.clr = ($urandom_range(0, 15) == 0);
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        bus.clr = 1'b0;
        hold(1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
